// File: rtl/signed_serial_pkg.sv
// -----------------------------------------------------------------------------
// signed_serial_pkg
// Shared definitions for the bit-serial signed subtractor:
//   state_t          - FSM state encoding (IDLE, RUN, DONE), 2 bits.
//   sub_overflow_ref - reference signed-overflow rule for a - b, written in
//                      terms of the operand and result sign bits so the bench
//                      can reuse it at any width.
// -----------------------------------------------------------------------------
package signed_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // a - b overflows only when the operands have different signs and the
  // wrapped result takes the sign of the subtrahend rather than the minuend.
  function automatic logic sub_overflow_ref(input logic a_msb,
                                            input logic b_msb,
                                            input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// One-bit combinational full adder, the single arithmetic cell shared by the
// serial subtractor.
//   x, y  : addend bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out (majority of x, y, cin)
// -----------------------------------------------------------------------------
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/signed_sub_serial.sv
// -----------------------------------------------------------------------------
// signed_sub_serial
// Bit-serial two's-complement subtractor. Operands are accepted on a
// valid/ready handshake, a - b is formed LSB-first as a + ~b + 1 through one
// shared full-adder cell, and the WIDTH-bit wrapped difference plus a signed
// overflow flag are offered on a second valid/ready handshake.
//   WIDTH      : operand/result width (2..32)
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands a, b present
//   in_ready   : block idle, operands accepted on in_valid & in_ready
//   a, b       : minuend and subtrahend
//   out_valid  : diff/overflow valid (held until out_ready)
//   out_ready  : consumer takes the result
//   diff       : (a - b) mod 2^WIDTH
//   overflow   : signed result out of range
// Latency is WIDTH cycles from accept to out_valid; all outputs are flops.
// -----------------------------------------------------------------------------
module signed_sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             overflow
);

  import signed_serial_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;

  full_adder_bit u_fa (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // diff doubles as the result shift register: after WIDTH shifts from the
  // MSB end every bit has been overwritten, so no clear is needed per op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      overflow  <= 1'b0;
      sa        <= '0;
      sb        <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa       <= a;
            sb       <= ~b;
            carry    <= 1'b1;   // the +1 of a + ~b + 1
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          diff  <= {fa_s, diff[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            // carry into the MSB vs carry out of it flags signed overflow
            overflow  <= carry ^ fa_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_sub_serial.sv
module tb_signed_sub_serial;

  import signed_serial_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // scoreboard entries: {expected diff, expected overflow}
  logic [W:0] sb_q[$];

  signed_sub_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model: integer subtraction and range test.
  function automatic logic [W:0] model(input logic [W-1:0] ea, input logic [W-1:0] eb);
    int r;
    logic [W-1:0] d;
    logic ov;
    r  = int'($signed(ea)) - int'($signed(eb));
    d  = W'(r);
    ov = (r > 7) || (r < -8);
    return {d, ov};
  endfunction

  // Wait for in_ready, present operands for one edge; optionally push expected.
  task automatic issue(input logic [W-1:0] ea, input logic [W-1:0] eb, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout in_ready=%0b required=1", in_ready);
    end
    a = ea;
    b = eb;
    in_valid = 1'b1;
    if (push) sb_q.push_back(model(ea, eb));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), compare against scoreboard head, drain.
  task automatic collect(input string name, input int exp_lat);
    int lat;
    logic [W:0] e;
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 40) break;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout out_valid=%0b required=1", name, out_valid);
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected diff=%h required=none", name, diff);
      return;
    end
    e = sb_q.pop_front();
    if ({diff, overflow} !== e) begin
      errors++;
      $display("FAIL %s diff=%h ov=%0b required diff=%h ov=%0b", name, diff, overflow, e[W:1], e[0]);
    end
    if (exp_lat >= 0) begin
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL %s_latency got=%0d required=%0d", name, lat, exp_lat);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, diff, overflow} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state rdy=%0b vld=%0b diff=%h ov=%0b required 1 0 0 0",
               in_ready, out_valid, diff, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    issue(4'd3, 4'd5, 1'b1);
    collect("basic_3_5", W);
  endtask

  task automatic test_boundaries();
    issue(4'd7, 4'hF, 1'b1); collect("pos_ov_7_m1", W);
    issue(4'd0, 4'h8, 1'b1); collect("pos_ov_0_m8", W);
    issue(4'hF, 4'd7, 1'b1); collect("neg_m1_7", W);
    issue(4'h8, 4'h8, 1'b1); collect("neg_m8_m8", W);
    issue(4'h8, 4'd1, 1'b1); collect("neg_ov_m8_1", W);
  endtask

  task automatic test_backpressure();
    logic [W:0] e;
    out_ready = 1'b0;
    issue(4'd2, 4'hD, 1'b1);          // 2 - (-3) = 5
    e = model(4'd2, 4'hD);
    repeat (W + 1) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a = 4'd1; b = 4'd1; in_valid = 1'b1;   // must be ignored
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, diff, overflow} !== {1'b1, 1'b0, e}) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d vld=%0b rdy=%0b diff=%h ov=%0b required 1 0 %h %0b",
                 i, out_valid, in_ready, diff, overflow, e[W:1], e[0]);
      end
    end
    in_valid = 1'b0;
    collect("backpressure_drain", 0);
    issue(4'd4, 4'd6, 1'b1);
    collect("after_backpressure", W);
  endtask

  task automatic test_reset_mid_run();
    issue(4'd6, 4'hD, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, diff, overflow} !== {1'b0, 1'b1, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_run vld=%0b rdy=%0b diff=%h ov=%0b required 0 1 0 0",
               out_valid, in_ready, diff, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd6, 4'hD, 1'b1);
    collect("after_reset_6_m3", W);
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] ea, eb, ed;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        ea = W'(i);
        eb = W'(j);
        ed = ea - eb;
        // expected overflow from the package reference rule
        sb_q.push_back({ed, sub_overflow_ref(ea[W-1], eb[W-1], ed[W-1])});
        issue(ea, eb, 1'b0);
        collect("exhaustive", W);
      end
    end
  endtask

  initial begin
    test_reset();
    issue(4'd3, 4'd5, 1'b1);
    collect("basic_3_5", W);
    test_boundaries();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
